// File: rtl/reg_writeback_if.sv
// Bundle of the writeback-controller signals: issue, ALU and load results,
// the register-file write port and the decode hazard queries.
interface reg_writeback_if;
    logic        issue_valid;
    logic [4:0]  issue_rd;

    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;

    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_data;

    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rs1_fwd;
    logic        rs2_fwd;

    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_funct3, ld_data,
        input  reg_write, rd_addr, rd_data,
        output rs1_addr, rs2_addr,
        input  rs1_busy, rs2_busy, rs1_fwd, rs2_fwd
    );

    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_funct3, ld_data,
        output reg_write, rd_addr, rd_data,
        input  rs1_addr, rs2_addr,
        output rs1_busy, rs2_busy, rs1_fwd, rs2_fwd
    );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write-port controller: load/ALU arbitration, ALU result FIFO,
// load extension and pending-write scoreboard. WB_BYPASS_EN enables rd_data forwarding.
module reg_writeback #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    reg_writeback_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [4:0]       fifo_rd   [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             fifo_full;
    logic             fifo_empty;
    logic             alu_accept;
    logic             push;
    logic             pop;

    logic             sel_valid;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;

    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;

    logic [31:0]      pending;
    logic [31:0]      pending_next;

    function automatic logic [31:0] extend_load(input logic [2:0] funct3,
                                                input logic [31:0] raw);
        logic [31:0] result;
        case (funct3)
            3'b000:  result = {{24{raw[7]}}, raw[7:0]};
            3'b001:  result = {{16{raw[15]}}, raw[15:0]};
            3'b100:  result = {24'd0, raw[7:0]};
            3'b101:  result = {16'd0, raw[15:0]};
            default: result = raw;
        endcase
        return result;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Ready comes only from the registered count, so a full FIFO never pops through.
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign alu_accept = bus.alu_valid && !fifo_full;

    assign bus.alu_ready = !fifo_full;

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (bus.ld_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.ld_rd;
            sel_data  = extend_load(bus.ld_funct3, bus.ld_data);
            push      = alu_accept;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd[head];
            sel_data  = fifo_data[head];
            pop       = 1'b1;
            push      = alu_accept;
        end else if (alu_accept) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_data  = bus.alu_data;
        end
    end

    // Payload storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= bus.alu_rd;
            fifo_data[tail] <= bus.alu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Address and data hold across idle cycles; x0 results update them without a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                wb_addr <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

    assign bus.reg_write = wb_en;
    assign bus.rd_addr   = wb_addr;
    assign bus.rd_data   = wb_data;

    // Clear is applied first so a same-cycle issue to the committing register wins.
    always_comb begin
        pending_next = pending;
        if (wb_en) pending_next[wb_addr] = 1'b0;
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) pending_next[bus.issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= pending_next;
    end

`ifdef WB_BYPASS_EN
    assign bus.rs1_fwd = wb_en && (wb_addr == bus.rs1_addr) && (bus.rs1_addr != 5'd0);
    assign bus.rs2_fwd = wb_en && (wb_addr == bus.rs2_addr) && (bus.rs2_addr != 5'd0);
`else
    assign bus.rs1_fwd = 1'b0;
    assign bus.rs2_fwd = 1'b0;
`endif

    assign bus.rs1_busy = pending[bus.rs1_addr] && (bus.rs1_addr != 5'd0) && !bus.rs1_fwd;
    assign bus.rs2_busy = pending[bus.rs2_addr] && (bus.rs2_addr != 5'd0) && !bus.rs2_fwd;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_reg_writeback;

    localparam int DEPTH = 2;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    reg_writeback_if wb ();

    reg_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    logic [31:0] pending_m;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference extension computed with integer arithmetic on the loaded value.
    function automatic logic [31:0] modelExtend(input logic [2:0] f3, input logic [31:0] d);
        int v;
        case (f3)
            3'd0: begin v = int'(d & 32'hFF);   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = int'(d & 32'hFFFF); if (v >= 32768) v = v - 65536; end
            3'd4: v = int'(d & 32'hFF);
            3'd5: v = int'(d & 32'hFFFF);
            default: v = int'(d);
        endcase
        return 32'(v);
    endfunction

    function automatic logic expFwd(input logic [4:0] rs);
`ifdef WB_BYPASS_EN
        return exp_we && (exp_addr == rs) && (rs != 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic expBusy(input logic [4:0] rs);
        return pending_m[rs] && (rs != 5'd0) && !expFwd(rs);
    endfunction

    task automatic modelReset();
        q.delete();
        pending_m = '0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
    endtask

    // One clock cycle: starts just after a falling edge, ends on the next falling edge.
    task automatic applyStimulus(
        input logic iv, input logic [4:0] ird,
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic lv, input logic [4:0] lrd, input logic [2:0] lf3, input logic [31:0] ld,
        input logic [4:0] r1, input logic [4:0] r2);
        wr_t  w;
        logic has;
        logic acc;
        wb.issue_valid = iv;  wb.issue_rd  = ird;
        wb.alu_valid   = av;  wb.alu_rd    = ard; wb.alu_data = ad;
        wb.ld_valid    = lv;  wb.ld_rd     = lrd; wb.ld_funct3 = lf3; wb.ld_data = ld;
        wb.rs1_addr    = r1;  wb.rs2_addr  = r2;
        #1;
        checkOutput("alu_ready", wb.alu_ready, (q.size() < DEPTH));
        checkOutput("rs1_busy",  wb.rs1_busy,  expBusy(r1));
        checkOutput("rs2_busy",  wb.rs2_busy,  expBusy(r2));
        checkOutput("rs1_fwd",   wb.rs1_fwd,   expFwd(r1));
        checkOutput("rs2_fwd",   wb.rs2_fwd,   expFwd(r2));

        acc = av && (q.size() < DEPTH);
        has = 1'b0;
        w   = '{rd: 5'd0, data: 32'd0};
        if (lv) begin
            w   = '{rd: lrd, data: modelExtend(lf3, ld)};
            has = 1'b1;
            if (acc) q.push_back('{rd: ard, data: ad});
        end else if (q.size() > 0) begin
            w   = q.pop_front();
            has = 1'b1;
            if (acc) q.push_back('{rd: ard, data: ad});
        end else if (acc) begin
            w   = '{rd: ard, data: ad};
            has = 1'b1;
        end
        if (exp_we) pending_m[exp_addr] = 1'b0;
        if (iv && ird != 5'd0) pending_m[ird] = 1'b1;
        exp_we = has && (w.rd != 5'd0);
        if (has) begin
            exp_addr = w.rd;
            exp_data = w.data;
        end

        @(posedge clk);
        @(negedge clk);
        checkOutput("reg_write", wb.reg_write, exp_we);
        checkOutput("rd_addr",   wb.rd_addr,   exp_addr);
        checkOutput("rd_data",   wb.rd_data,   exp_data);
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        modelReset();
        reset = 1'b1;
        wb.issue_valid = 0; wb.issue_rd = 0;
        wb.alu_valid = 0; wb.alu_rd = 0; wb.alu_data = 0;
        wb.ld_valid = 0; wb.ld_rd = 0; wb.ld_funct3 = 0; wb.ld_data = 0;
        wb.rs1_addr = 0; wb.rs2_addr = 0;
        #1;
        checkOutput("rst_reg_write", wb.reg_write, 0);
        checkOutput("rst_rd_addr",   wb.rd_addr,   0);
        checkOutput("rst_rd_data",   wb.rd_data,   0);
        checkOutput("rst_alu_ready", wb.alu_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Issue x5 then its ALU result.
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        applyStimulus(0, 0, 1, 5, 32'h1234, 0, 0, 0, 0, 5, 0);
        checkOutput("tp1_we",   wb.reg_write, 1);
        checkOutput("tp1_addr", wb.rd_addr,   5);
        checkOutput("tp1_data", wb.rd_data,   32'h1234);
        idle(2, 5, 0);

        // Load and ALU together: load first, ALU next cycle.
        applyStimulus(0, 0, 1, 4, 32'h7, 1, 3, 3'b000, 32'h80, 0, 0);
        checkOutput("tp2_lb", wb.rd_data, 32'hFFFF_FF80);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("tp2_alu", wb.rd_data, 32'h7);

        // Extension variants.
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 3'b101, 32'hABCD_8001, 0, 0);
        checkOutput("ext_lhu", wb.rd_data, 32'h0000_8001);
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 3'b001, 32'hABCD_8001, 0, 0);
        checkOutput("ext_lh", wb.rd_data, 32'hFFFF_8001);
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 3'b011, 32'hABCD_8001, 0, 0);
        checkOutput("ext_011", wb.rd_data, 32'hABCD_8001);
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 3'b100, 32'hABCD_80F1, 0, 0);
        checkOutput("ext_lbu", wb.rd_data, 32'h0000_00F1);

        // Back-pressure: four load cycles with ALU always valid.
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 1, 5'(10 + i), 32'(100 + i), 1, 5'(20 + i), 3'b010, 32'(200 + i), 0, 0);
        checkOutput("bp_ready_low", wb.alu_ready, 0);
        idle(3, 0, 0);

        // x0 result never writes and x0 is never busy.
        applyStimulus(1, 0, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_we", wb.reg_write, 0);
        checkOutput("x0_busy", wb.rs1_busy, 0);
        idle(1, 0, 0);

        // Forwarding query while the x7 write is on the port.
        applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        applyStimulus(0, 0, 1, 7, 32'h77, 0, 0, 0, 0, 0, 7);
        wb.rs2_addr = 7;
        #1;
`ifdef WB_BYPASS_EN
        checkOutput("x7_fwd",  wb.rs2_fwd,  1);
        checkOutput("x7_busy", wb.rs2_busy, 0);
`else
        checkOutput("x7_fwd",  wb.rs2_fwd,  0);
        checkOutput("x7_busy", wb.rs2_busy, 1);
`endif
        idle(2, 7, 7);

        // Reset mid-operation with two FIFO entries held.
        applyStimulus(1, 12, 1, 12, 32'hAAAA, 1, 13, 3'b010, 32'h1, 12, 13);
        applyStimulus(0, 0, 1, 14, 32'hBBBB, 1, 15, 3'b010, 32'h2, 12, 13);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("mid_rst_we",    wb.reg_write, 0);
        checkOutput("mid_rst_addr",  wb.rd_addr,   0);
        checkOutput("mid_rst_data",  wb.rd_data,   0);
        checkOutput("mid_rst_ready", wb.alu_ready, 1);
        checkOutput("mid_rst_busy",  wb.rs1_busy,  0);
        wb.alu_valid = 0;
        wb.ld_valid  = 0;
        wb.issue_valid = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(4, 12, 14);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic       iv;
            logic [4:0] ird;
            iv  = ($urandom_range(0, 99) < 40);
            ird = 5'($urandom_range(0, 31));
            if (pending_m[ird]) iv = 1'b0;
            applyStimulus(iv, ird,
                          ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)),
                          3'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(4, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-port controller for the 32x32 register file. It collects ALU results and load results, arbitrates them onto the single register-file write port, sign- or zero-extends load data, and keeps a 32-bit pending-write scoreboard. Decode queries that scoreboard to detect RAW hazards. The block sits between the execute/memory stages and the register file's `reg_write`/`rd_addr`/`rd_data` inputs.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: ALU result buffer entries. Must be ≥1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `issue_valid` in 1: decode issues an instruction that writes `issue_rd`.
- `issue_rd` in 5: destination register being issued.
- `alu_valid` in 1: ALU result offered.
- `alu_ready` out 1: ALU result accepted this cycle when high.
- `alu_rd` in 5: ALU destination.
- `alu_data` in 32: ALU result.
- `ld_valid` in 1: load result present. It is always accepted and has no ready.
- `ld_rd` in 5: load destination.
- `ld_funct3` in 3: load type.
- `ld_data` in 32: raw load data, right-aligned.
- `reg_write` out 1: register-file write enable.
- `rd_addr` out 5: register-file write address.
- `rd_data` out 32: register-file write data.
- `rs1_addr`, `rs2_addr` in 5: decode source query.
- `rs1_busy`, `rs2_busy` out 1: a write to the source register is pending.
- `rs1_fwd`, `rs2_fwd` out 1: `rd_data` may be forwarded to that source (see Configuration).

## Operation
- Scoreboard: `pending[31:0]`.
  - Set on `issue_valid && issue_rd!=0`.
  - Cleared at the edge where its write is emitted on the output port.
  - If set and clear hit the same register in the same cycle, set wins.
  - Upstream never issues to an already-pending rd. Behaviour on a WAW violation is undefined.
- `rsN_busy = pending[rsN_addr] && rsN_addr!=0`. Combinational.
- Write-slot priority, one write per cycle:
  1. `ld_valid`.
  2. FIFO head, if the FIFO is non-empty.
  3. The incoming ALU result, direct. This path is used only when the FIFO is empty.
- ALU handshake:
  - `alu_ready = !fifo_full`, derived from the registered count. There is no pop-through.
  - An accepted ALU result that does not win the slot is pushed into the FIFO.
  - If load and ALU arrive together with the FIFO not full, the load writes and the ALU result is pushed.
  - The FIFO keeps order, so ALU results commit in acceptance order.
- Load extension by `ld_funct3`:
  - 000: LB, sign-extend `[7:0]`.
  - 001: LH, sign-extend `[15:0]`.
  - 100: LBU, zero-extend `[7:0]`.
  - 101: LHU, zero-extend `[15:0]`.
  - 010 and all other codes: pass the full word.
- x0: a result with rd=0 still consumes its slot or FIFO entry, but emits `reg_write=0`. `rd_addr`/`rd_data` still update.

## Timing
- The output port is registered. The write appears one cycle after the winning source is present, and the register file commits it at the following edge.
- A pending bit clears at the same edge the register file commits, i.e. the edge ending the cycle with `reg_write=1`.
- Reset (async) values:
  - `reg_write`=0, `rd_addr`=0, `rd_data`=0.
  - pending=0, FIFO empty, so `alu_ready`=1.
  - busy=0 and fwd=0.
- Reset asserted mid-operation discards FIFO contents and in-flight output. No write is emitted after reset deasserts until a new result arrives.
- FIFO full with `ld_valid`: the load writes, the FIFO holds, and `alu_ready` stays 0.
- FIFO full with no load: the head pops. `alu_ready` rises the next cycle.
- Idle cycles: `reg_write`=0. `rd_addr`/`rd_data` hold their last values.

## Configuration
- `WB_BYPASS_EN` defined:
  - `rsN_fwd = reg_write && rd_addr==rsN_addr && rsN_addr!=0`.
  - `rsN_busy` is forced to 0 whenever `rsN_fwd`=1. Decode muxes `rd_data` in place of the register-file read.
- Undefined:
  - `rs1_fwd`/`rs2_fwd` are tied to 0.
  - busy stays high through the commit cycle, and decode stalls one extra cycle.

## Test plan
- Issue rd=5, then ALU result rd=5 data=0x1234. Required: `rs1_busy`(5)=1; one cycle later `reg_write`=1, `rd_addr`=5, `rd_data`=0x1234; the following cycle busy=0.
- Load and ALU in the same cycle: load rd=3, LB, `ld_data`=0x80; ALU rd=4, 0x7. Required: cycle+1 writes x3=0xFFFFFF80; cycle+2 writes x4=0x7.
- Extension: LHU of 0xABCD8001 → 0x00008001; LH → 0xFFFF8001; `ld_funct3`=011 → 0xABCD8001.
- Back-pressure: hold `ld_valid` for 4 cycles while ALU is valid every cycle. Required: `alu_ready` falls after 2 accepts; ALU writes emerge in order once loads stop.
- ALU rd=0, data=0xFFFF. Required: `reg_write` stays 0 and the x0 query busy stays 0. Separately, assert reset with the FIFO holding 2 entries. Required: outputs go to 0 immediately and no stale write follows.
- With `WB_BYPASS_EN`: while the x7 write is on the port, `rs2_addr`=7. Required: `rs2_fwd`=1, `rs2_busy`=0. Without the macro: `rs2_fwd`=0, `rs2_busy`=1.
